// File: rtl/iter_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu_if
// Description : Handshake bundle for iter_alu. The operand side and the
//               result side each use valid/ready. The master drives requests
//               and accepts results; the slave is the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, flag_c, flag_z, flag_n
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, flag_c, flag_z, flag_n
    );
endinterface
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu
// Description : Handshaked multi-cycle WIDTH-bit ALU. ADD/SUB/NAND/XOR finish
//               in one cycle; SRL/SRA/SLL shift one bit per cycle; MUL is an
//               LSB-first shift-add, one partial product per cycle.
//               Optional feature macro: ITER_ALU_MUL_EN (builds the
//               multiplier; without it op 111 returns 0 in one cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module iter_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    iter_alu_if.slave   bus
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // MUL needs to count WIDTH iterations; shifts only ever need WIDTH-1.
`ifdef ITER_ALU_MUL_EN
    localparam int CNTW = SHW + 1;
`else
    localparam int CNTW = SHW;
`endif

    logic [1:0]       state_q, state_d;
    logic             rdy_q;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             fc_q, fc_d;
    logic             fz_q, fz_d;
    logic             fn_q, fn_d;
`ifdef ITER_ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

    logic [SHW-1:0]   w_k;
    logic             w_shift;
    logic             w_iter;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_y1;
    logic             w_c1;
    logic [WIDTH-1:0] w_step;
    logic             w_step_c;

    assign w_k     = bus.b[SHW-1:0];
    assign w_shift = (bus.op == OP_SRL) || (bus.op == OP_SRA) || (bus.op == OP_SLL);
`ifdef ITER_ALU_MUL_EN
    assign w_iter  = (w_shift && (w_k != '0)) || (bus.op == OP_MUL);
`else
    assign w_iter  = w_shift && (w_k != '0);
`endif

    // Single-cycle result, computed straight from the incoming operands
    always_comb begin
        w_sum = {1'b0, bus.a} + {1'b0, bus.b};
        w_dif = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        w_y1  = '0;
        w_c1  = 1'b0;
        case (bus.op)
            OP_ADD:  begin w_y1 = w_sum[WIDTH-1:0]; w_c1 = w_sum[WIDTH]; end
            OP_SUB:  begin w_y1 = w_dif[WIDTH-1:0]; w_c1 = w_dif[WIDTH]; end
            OP_NAND: w_y1 = ~(bus.a & bus.b);
            OP_XOR:  w_y1 = bus.a ^ bus.b;
            OP_MUL:  w_y1 = '0;      // only reached when the multiplier is not built
            default: w_y1 = bus.a;   // shift by zero passes the operand through
        endcase
    end

    // One iteration of the captured operation; the carry is the bit shifted out
    always_comb begin
        w_step   = acc_q;
        w_step_c = 1'b0;
        case (op_q)
            OP_SRL: begin w_step = {1'b0, acc_q[WIDTH-1:1]};          w_step_c = acc_q[0];       end
            OP_SRA: begin w_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; w_step_c = acc_q[0];       end
            OP_SLL: begin w_step = {acc_q[WIDTH-2:0], 1'b0};          w_step_c = acc_q[WIDTH-1]; end
`ifdef ITER_ALU_MUL_EN
            OP_MUL: w_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
            default: ;
        endcase
    end

    // Next-state and datapath control; y/flags only load when DONE is entered
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
`ifdef ITER_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && rdy_q) begin
                    op_d = bus.op;
                    if (w_iter) begin
                        state_d = S_BUSY;
                        acc_d   = bus.a;
                        cnt_d   = CNTW'(w_k);
`ifdef ITER_ALU_MUL_EN
                        if (bus.op == OP_MUL) begin
                            acc_d    = '0;
                            mcand_d  = bus.a;
                            mplier_d = bus.b;
                            cnt_d    = CNTW'(WIDTH);
                        end
`endif
                    end else begin
                        state_d = S_DONE;
                        y_d     = w_y1;
                        fc_d    = w_c1;
                        fz_d    = (w_y1 == '0);
                        fn_d    = w_y1[WIDTH-1];
                    end
                end
            end
            S_BUSY: begin
                acc_d = w_step;
                cnt_d = cnt_q - CNTW'(1);
`ifdef ITER_ALU_MUL_EN
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
                if (cnt_q == CNTW'(1)) begin
                    state_d = S_DONE;
                    y_d     = w_step;
                    fc_d    = w_step_c;
                    fz_d    = (w_step == '0);
                    fn_d    = w_step[WIDTH-1];
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
        end
    end

`ifdef ITER_ALU_MUL_EN
    // Multiplicand/multiplier shift registers for the shift-add multiply
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    // rdy_q keeps in_ready low while reset is held, even though state is IDLE
    assign bus.in_ready  = (state_q == S_IDLE) && rdy_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.y         = y_q;
    assign bus.flag_c    = fc_q;
    assign bus.flag_z    = fz_q;
    assign bus.flag_n    = fn_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_alu
// Description : Self-checking bench for iter_alu (WIDTH=8): directed vector
//               table, backpressure and mid-operation reset sequences, and
//               randomized operations against a behavioural model.
//               Honours ITER_ALU_MUL_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_alu;

    localparam int W = 8;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         c;
        logic         z;
        logic         n;
        int           lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    iter_alu_if #(.WIDTH(W)) bus ();

    iter_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model straight from the arithmetic rules
    function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t r;
        int   k;
        int   s;
        k     = int'(b) % W;
        r.op  = op;
        r.a   = a;
        r.b   = b;
        r.c   = 1'b0;
        r.lat = 1;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r.y = W'(s); r.c = (s >= (1 << W)); end
            3'd1: begin r.y = W'(int'(a) - int'(b)); r.c = (a >= b); end
            3'd2: r.y = ~(a & b);
            3'd4: r.y = a ^ b;
            3'd3: begin r.y = a >> k; r.c = (k != 0) ? a[k-1] : 1'b0; r.lat = 1 + k; end
            3'd5: begin r.y = W'($signed(a) >>> k); r.c = (k != 0) ? a[k-1] : 1'b0; r.lat = 1 + k; end
            3'd6: begin r.y = a << k; r.c = (k != 0) ? a[W-k] : 1'b0; r.lat = 1 + k; end
            default: begin
`ifdef ITER_ALU_MUL_EN
                r.y = W'(int'(a) * int'(b)); r.lat = W + 1;
`else
                r.y = '0;
`endif
            end
        endcase
        r.z = (r.y == '0);
        r.n = r.y[W-1];
        return r;
    endfunction

    // Issue one operation, check latency/result, hold backpressure, release
    task automatic run_op(input string tag, input vec_t v, input int hold);
        int w;
        int lat;
        logic [W-1:0] y_seen;
        w = 0;
        while (!bus.in_ready && w < 20) begin tick(); w++; end
        if (!bus.in_ready) begin
            chk({tag, ".in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.op        = v.op;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.out_ready = (hold == 0);
        tick();
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
        chk({tag, ".y"},   32'(bus.y), 32'(v.y));
        chk({tag, ".c"},   32'(bus.flag_c), 32'(v.c));
        chk({tag, ".z"},   32'(bus.flag_z), 32'(v.z));
        chk({tag, ".n"},   32'(bus.flag_n), 32'(v.n));
        y_seen = bus.y;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_y"},     32'(bus.y), 32'(v.y));
            chk({tag, ".hold_rdy"},   32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk({tag, ".rel_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".rel_rdy"},   32'(bus.in_ready), 32'd1);
        chk({tag, ".rel_y"},     32'(bus.y), 32'(y_seen));
    endtask

    vec_t tbl[12];

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;

        //             op     a      b      y      c  z  n  lat
        tbl[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1};
        tbl[1]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 0, 0, 1, 1};
        tbl[2]  = '{3'd1, 8'h07, 8'h05, 8'h02, 1, 0, 0, 1};
        tbl[3]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1};
        tbl[4]  = '{3'd2, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 1};
        tbl[5]  = '{3'd4, 8'hA5, 8'hFF, 8'h5A, 0, 0, 0, 1};
        tbl[6]  = '{3'd6, 8'h81, 8'h00, 8'h81, 0, 0, 1, 1};
        tbl[7]  = '{3'd6, 8'h81, 8'h01, 8'h02, 1, 0, 0, 2};
        tbl[8]  = '{3'd3, 8'h81, 8'h07, 8'h01, 0, 0, 0, 8};
        tbl[9]  = '{3'd5, 8'h90, 8'h03, 8'hF2, 0, 0, 1, 4};
        tbl[10] = '{3'd5, 8'h7F, 8'h0C, 8'h07, 1, 0, 0, 5};
`ifdef ITER_ALU_MUL_EN
        tbl[11] = '{3'd7, 8'h0D, 8'h0B, 8'h8F, 0, 0, 1, 9};
`else
        tbl[11] = '{3'd7, 8'h0D, 8'h0B, 8'h00, 0, 1, 0, 1};
`endif

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.y",     32'(bus.y), 32'd0);
            chk("rst.c",     32'(bus.flag_c), 32'd0);
            chk("rst.z",     32'(bus.flag_z), 32'd0);
            chk("rst.n",     32'(bus.flag_n), 32'd0);
            chk("rst.valid", 32'(bus.out_valid), 32'd0);
            chk("rst.rdy",   32'(bus.in_ready), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("rst.rdy_after", 32'(bus.in_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i], 0);
        end

        // SRA with five cycles of backpressure
        run_op("sra_bp", tbl[9], 5);

        // Reset on the 3rd BUSY cycle of SRL 0xFF by 7
        begin
            int w;
            w = 0;
            while (!bus.in_ready && w < 20) begin tick(); w++; end
            bus.in_valid  = 1'b1;
            bus.op        = 3'd3;
            bus.a         = 8'hFF;
            bus.b         = 8'h07;
            bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk("midrst.busy1_valid", 32'(bus.out_valid), 32'd0);
            tick();
            chk("midrst.busy2_valid", 32'(bus.out_valid), 32'd0);
            tick();
            chk("midrst.busy3_valid", 32'(bus.out_valid), 32'd0);
            rst_n = 1'b0;
            tick();
            chk("midrst.valid", 32'(bus.out_valid), 32'd0);
            chk("midrst.y",     32'(bus.y), 32'd0);
            chk("midrst.rdy",   32'(bus.in_ready), 32'd0);
            tick();
            chk("midrst.valid2", 32'(bus.out_valid), 32'd0);
            rst_n = 1'b1;
            for (int i = 0; i < 9; i++) begin
                tick();
                chk("midrst.never_valid", 32'(bus.out_valid), 32'd0);
                chk("midrst.idle_rdy",    32'(bus.in_ready), 32'd1);
            end
            run_op("midrst.xor", tbl[5], 0);
        end

        // Randomized operations against the model
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v = model(3'($urandom), W'($urandom), W'($urandom));
            run_op($sformatf("rnd%0d_op%0d", i, v.op), v, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
